// File: rtl/octave_decimator.sv
// Purpose: halves an octave stream in both dimensions (keep top-left or 2x2 rounded mean) and forwards blanking.
// Latency: 1 cycle from the pixel that completes a 2x2 block (or from a blanking token) to validout.
// Backpressure: none; every input cycle is consumed, and the output is a one-cycle strobe.
module octave_decimator #(
    parameter int width   = 420,
    parameter int height  = 320,
    parameter int average = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       validin,
    input  logic       blanking_in,
    output logic [7:0] dout,
    output logic       validout,
    output logic       blanking_out,
    output logic       frame_done,
    output logic       error
);

    localparam int CW   = (width > 1) ? $clog2(width) : 1;
    localparam int RW   = (height > 1) ? $clog2(height) : 1;
    localparam int HALF = width / 2;
    localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(width - 1);
    localparam logic [CW-1:0] COL_PEN  = CW'(width - 2);
    localparam logic [RW-1:0] ROW_LAST = RW'(height - 1);
    localparam logic [RW-1:0] ROW_PEN  = RW'(height - 2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic pix_in;
    logic tok_in;
    logic col_last;
    logic row_last;
    logic abort;

    // Per-cycle decode of the incoming token and the raster position.
    assign pix_in   = validin & ~blanking_in;
    assign tok_in   = validin & blanking_in;
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    // A blanking token arriving inside a line means the line was cut short.
    assign abort    = tok_in & (col != '0);

    // Emission request from the mode-specific datapath below.
    logic       emit;
    logic [7:0] emit_val;
    logic       emit_last;

    // Raster counters: advance on active pixels, abandon the line on a mid-line token.
    always_ff @(posedge clock) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (pix_in) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end else if (abort) begin
            col <= '0;
            row <= row_last ? '0 : row + 1'b1;
        end
    end

    generate
        if (average == 0) begin : g_keep
            // Plain decimation: the top-left pixel of every 2x2 block passes straight through.
            assign emit      = pix_in & ~row[0] & ~col[0];
            assign emit_val  = din;
            // The last kept pixel of a frame sits one row and one column before the corner.
            assign emit_last = (row == ROW_PEN) && (col == COL_PEN);
        end else begin : g_avg
            logic [7:0]    hl;
            logic [8:0]    lb [HALF];
            logic [LW-1:0] lb_idx;
            logic [9:0]    sum;
            logic [7:0]    mean;

            assign lb_idx = LW'(col >> 1);

            // Left pixel of the current horizontal pair, on both even and odd rows.
            always_ff @(posedge clock) begin
                if (pix_in && !col[0]) begin
                    hl <= din;
                end
            end

            // Even rows park the horizontal pair sum until the odd row below completes the block.
            always_ff @(posedge clock) begin
                if (pix_in && !row[0] && col[0]) begin
                    lb[lb_idx] <= {1'b0, hl} + {1'b0, din};
                end
            end

            // Four 8-bit samples plus rounding fit in 10 bits; the quotient never exceeds 255.
            assign sum       = {1'b0, lb[lb_idx]} + {2'b00, hl} + {2'b00, din} + 10'd2;
            assign mean      = 8'(sum >> 2);
            assign emit      = pix_in & row[0] & col[0];
            assign emit_val  = mean;
            assign emit_last = row_last & col_last;
        end
    endgenerate

    // Registered output stage: tokens and completed blocks strobe, idle cycles hold data.
    always_ff @(posedge clock) begin
        if (reset) begin
            dout         <= 8'd0;
            validout     <= 1'b0;
            blanking_out <= 1'b1;
            frame_done   <= 1'b0;
            error        <= 1'b0;
        end else begin
            validout   <= 1'b0;
            frame_done <= 1'b0;
            if (tok_in) begin
                validout     <= 1'b1;
                blanking_out <= 1'b1;
                dout         <= 8'd0;
                if (abort) begin
                    error <= 1'b1;
                end
            end else if (emit) begin
                validout     <= 1'b1;
                blanking_out <= 1'b0;
                dout         <= emit_val;
                frame_done   <= emit_last;
            end
        end
    end

endmodule

// File: tb/tb_octave_decimator.sv
module tb_octave_decimator;

    localparam int W = 8;
    localparam int H = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din = 8'd0;
    logic       validin = 1'b0;
    logic       blanking_in = 1'b0;

    logic [7:0] dout0, dout1;
    logic       validout0, validout1;
    logic       blank0, blank1;
    logic       fd0, fd1;
    logic       err0, err1;

    always #5 clock = ~clock;

    octave_decimator #(.width(W), .height(H), .average(0)) u_keep (
        .clock(clock), .reset(reset), .din(din), .validin(validin), .blanking_in(blanking_in),
        .dout(dout0), .validout(validout0), .blanking_out(blank0), .frame_done(fd0), .error(err0)
    );

    octave_decimator #(.width(W), .height(H), .average(1)) u_avg (
        .clock(clock), .reset(reset), .din(din), .validin(validin), .blanking_in(blanking_in),
        .dout(dout1), .validout(validout1), .blanking_out(blank1), .frame_done(fd1), .error(err1)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       b;
        logic       fd;
    } outrec_t;

    outrec_t    got_q [2][$];
    outrec_t    exp_q [2][$];
    int         checks = 0;
    int         failures = 0;
    int         stray_cnt = 0;
    logic       vin_q = 1'b0;
    logic [7:0] img [H][W];
    int         tok_after [H];

    // Output monitor: records every strobe and flags any strobe without an input the cycle before.
    always @(posedge clock) vin_q <= validin;

    always @(negedge clock) begin
        if (validout0 === 1'b1) begin
            got_q[0].push_back({dout0, blank0, fd0});
            if (vin_q !== 1'b1) stray_cnt++;
        end
        if (validout1 === 1'b1) begin
            got_q[1].push_back({dout1, blank1, fd1});
            if (vin_q !== 1'b1) stray_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            validin = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic b, input int gap);
        for (int g = 0; g < 8; g++) begin
            if ($urandom_range(99) >= gap) break;
            @(posedge clock); #1;
            validin = 1'b0;
        end
        @(posedge clock); #1;
        validin     = 1'b1;
        din         = d;
        blanking_in = b;
    endtask

    task automatic clear_q();
        for (int u = 0; u < 2; u++) begin
            got_q[u].delete();
            exp_q[u].delete();
        end
    endtask

    // Reference: a frame image decimates to kept/averaged pixels of each block,
    // emitted after the row that completes the block, followed by that row's tokens.
    task automatic model_frame();
        for (int r = 0; r < H; r++) begin
            if (r % 2 == 0) begin
                for (int c = 0; c < W; c += 2)
                    exp_q[0].push_back({img[r][c], 1'b0, (r == H - 2 && c == W - 2)});
            end else begin
                for (int c = 1; c < W; c += 2) begin
                    int s;
                    s = int'(img[r-1][c-1]) + int'(img[r-1][c]) + int'(img[r][c-1]) + int'(img[r][c]);
                    exp_q[1].push_back({8'((s + 2) / 4), 1'b0, (r == H - 1 && c == W - 1)});
                end
            end
            for (int k = 0; k < tok_after[r]; k++) begin
                exp_q[0].push_back({8'd0, 1'b1, 1'b0});
                exp_q[1].push_back({8'd0, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic drive_frame(input int gap);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) send(img[r][c], 1'b0, gap);
            for (int k = 0; k < tok_after[r]; k++) send(8'd0, 1'b1, gap);
        end
        idle(3);
    endtask

    task automatic ramp_image();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'(r * W + c);
        for (int r = 0; r < H; r++) tok_after[r] = 0;
    endtask

    task automatic test_reset();
        validin = 1'b1; blanking_in = 1'b0; din = 8'hA5;
        @(posedge clock); #1;
        reset = 1'b1;
        validin = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({dout0, validout0, blank0, fd0, err0} !== 12'b0000_0000_0100) begin
            failures++;
            $display("FAIL reset_keep got=%b want=%b", {dout0, validout0, blank0, fd0, err0}, 12'b0000_0000_0100);
        end
        checks++;
        if ({dout1, validout1, blank1, fd1, err1} !== 12'b0000_0000_0100) begin
            failures++;
            $display("FAIL reset_avg got=%b want=%b", {dout1, validout1, blank1, fd1, err1}, 12'b0000_0000_0100);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        clear_q();
    endtask

    task automatic test_ramp();
        logic [7:0] want0 [8] = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd16, 8'd18, 8'd20, 8'd22};
        logic [7:0] want1 [8] = '{8'd5, 8'd7, 8'd9, 8'd11, 8'd21, 8'd23, 8'd25, 8'd27};
        clear_q();
        ramp_image();
        model_frame();
        drive_frame(0);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (got_q[u].size() !== exp_q[u].size()) begin
                failures++;
                $display("FAIL ramp_count dut%0d got=%0d want=%0d", u, got_q[u].size(), exp_q[u].size());
            end
            for (int i = 0; i < got_q[u].size() && i < exp_q[u].size(); i++) begin
                checks++;
                if (got_q[u][i] !== exp_q[u][i]) begin
                    failures++;
                    $display("FAIL ramp dut%0d[%0d] got=%h want=%h", u, i, got_q[u][i], exp_q[u][i]);
                end
            end
        end
        for (int i = 0; i < 8 && i < got_q[0].size() && i < got_q[1].size(); i++) begin
            checks++;
            if (got_q[0][i].d !== want0[i] || got_q[1][i].d !== want1[i]) begin
                failures++;
                $display("FAIL ramp_table[%0d] got=%0d,%0d want=%0d,%0d", i, got_q[0][i].d, got_q[1][i].d, want0[i], want1[i]);
            end
        end
        if (got_q[0].size() == 8 && got_q[1].size() == 8) begin
            checks++;
            if (got_q[0][7].fd !== 1'b1 || got_q[1][7].fd !== 1'b1 || got_q[0][6].fd !== 1'b0) begin
                failures++;
                $display("FAIL ramp_frame_done got=%b%b%b want=110", got_q[0][7].fd, got_q[1][7].fd, got_q[0][6].fd);
            end
        end
    endtask

    task automatic test_saturation();
        clear_q();
        for (int r = 0; r < H; r++) begin
            tok_after[r] = 0;
            for (int c = 0; c < W; c++) img[r][c] = 8'($urandom_range(200, 255));
        end
        img[0][0] = 8'd255; img[0][1] = 8'd255; img[1][0] = 8'd255; img[1][1] = 8'd254;
        model_frame();
        drive_frame(0);
        checks++;
        if (got_q[1].size() == 0 || got_q[1][0].d !== 8'd255) begin
            failures++;
            $display("FAIL saturation got=%0d want=255", (got_q[1].size() == 0) ? -1 : int'(got_q[1][0].d));
        end
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (got_q[u].size() !== exp_q[u].size()) begin
                failures++;
                $display("FAIL sat_count dut%0d got=%0d want=%0d", u, got_q[u].size(), exp_q[u].size());
            end
            for (int i = 0; i < got_q[u].size() && i < exp_q[u].size(); i++) begin
                checks++;
                if (got_q[u][i] !== exp_q[u][i]) begin
                    failures++;
                    $display("FAIL sat dut%0d[%0d] got=%h want=%h", u, i, got_q[u][i], exp_q[u][i]);
                end
            end
        end
    endtask

    task automatic test_gaps_and_blanking(input int gap, input bit three_tokens, input bit random_pix);
        clear_q();
        stray_cnt = 0;
        if (random_pix) begin
            for (int r = 0; r < H; r++) begin
                tok_after[r] = $urandom_range(2);
                for (int c = 0; c < W; c++) img[r][c] = 8'($urandom);
            end
        end else begin
            ramp_image();
        end
        if (three_tokens) tok_after[1] = 3;
        model_frame();
        drive_frame(gap);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (got_q[u].size() !== exp_q[u].size()) begin
                failures++;
                $display("FAIL stream_count dut%0d got=%0d want=%0d", u, got_q[u].size(), exp_q[u].size());
            end
            for (int i = 0; i < got_q[u].size() && i < exp_q[u].size(); i++) begin
                checks++;
                if (got_q[u][i] !== exp_q[u][i]) begin
                    failures++;
                    $display("FAIL stream dut%0d[%0d] got=%h want=%h", u, i, got_q[u][i], exp_q[u][i]);
                end
            end
        end
        checks++;
        if (stray_cnt !== 0) begin
            failures++;
            $display("FAIL stray_strobe got=%0d want=0", stray_cnt);
        end
        checks++;
        if ({err0, err1} !== 2'b00) begin
            failures++;
            $display("FAIL no_error got=%b want=00", {err0, err1});
        end
    endtask

    task automatic test_mid_line_abort();
        clear_q();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'($urandom);
        for (int c = 0; c < 3; c++) send(img[0][c], 1'b0, 0);
        send(8'd0, 1'b1, 0);
        for (int r = 1; r < H; r++)
            for (int c = 0; c < W; c++) send(img[r][c], 1'b0, 0);
        idle(3);
        exp_q[0].push_back({img[0][0], 1'b0, 1'b0});
        exp_q[0].push_back({img[0][2], 1'b0, 1'b0});
        exp_q[0].push_back({8'd0, 1'b1, 1'b0});
        for (int c = 0; c < W; c += 2)
            exp_q[0].push_back({img[2][c], 1'b0, (c == W - 2)});
        checks++;
        if (got_q[0].size() !== exp_q[0].size()) begin
            failures++;
            $display("FAIL abort_count got=%0d want=%0d", got_q[0].size(), exp_q[0].size());
        end
        for (int i = 0; i < got_q[0].size() && i < exp_q[0].size(); i++) begin
            checks++;
            if (got_q[0][i] !== exp_q[0][i]) begin
                failures++;
                $display("FAIL abort[%0d] got=%h want=%h", i, got_q[0][i], exp_q[0][i]);
            end
        end
        checks++;
        if ({err0, err1} !== 2'b11) begin
            failures++;
            $display("FAIL abort_error got=%b want=11", {err0, err1});
        end
        // Partway into a new frame, then reset mid-frame.
        for (int c = 0; c < 5; c++) send(8'($urandom), 1'b0, 0);
        idle(2);
        checks++;
        if ({err0, err1} !== 2'b11) begin
            failures++;
            $display("FAIL error_sticky got=%b want=11", {err0, err1});
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({err0, err1} !== 2'b00) begin
            failures++;
            $display("FAIL reset_clears_error got=%b want=00", {err0, err1});
        end
        clear_q();
        for (int c = 0; c < W; c++) send(8'(100 + c), 1'b0, 0);
        for (int c = 0; c < W; c++) send(8'(10 * c), 1'b0, 0);
        idle(3);
        checks++;
        if (got_q[0].size() == 0 || got_q[0][0] !== {8'd100, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL post_reset_keep got=%h want=%h", (got_q[0].size() == 0) ? 10'h3ff : got_q[0][0], {8'd100, 1'b0, 1'b0});
        end
        // (100 + 101 + 0 + 10 + 2) >> 2 = 53
        checks++;
        if (got_q[1].size() == 0 || got_q[1][0] !== {8'd53, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL post_reset_avg got=%h want=%h", (got_q[1].size() == 0) ? 10'h3ff : got_q[1][0], {8'd53, 1'b0, 1'b0});
        end
        // Complete the frame so counters return to the origin.
        for (int r = 2; r < H; r++)
            for (int c = 0; c < W; c++) send(8'($urandom), 1'b0, 0);
        idle(3);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_saturation();
        test_gaps_and_blanking(50, 1'b0, 1'b0);
        test_gaps_and_blanking(0, 1'b1, 1'b0);
        for (int n = 0; n < 4; n++) test_gaps_and_blanking(30, 1'b0, 1'b1);
        test_mid_line_abort();
        test_ramp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
